// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// One single-word transfer at a time; waits out the controller's long ack.
module wb_sdram_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_cyc_i,
  input  logic [N_MASTERS-1:0]          m_stb_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  input  logic [DATA_W-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  output logic [N_MASTERS-1:0]          grant_o
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        own_q, own_d;
  logic [PW-1:0]        nxt;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] grant_d, ack_d, err_d;
  logic                 cyc_d, we_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdat_d, rdat_d;
  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW:0]          sum;
  logic [ADDR_W-1:0]    addr_a [N_MASTERS];
  logic [DATA_W-1:0]    wdat_a [N_MASTERS];

  assign req = m_cyc_i & m_stb_i;
  assign nxt = (own_q == PW'(N_MASTERS - 1)) ? '0 : own_q + 1'b1;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign addr_a[g] = m_addr_i[g*ADDR_W +: ADDR_W];
    assign wdat_a[g] = m_dat_i[g*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    grant_d = grant_o;
    ack_d   = '0;
    err_d   = '0;
    cyc_d   = s_cyc_o;
    we_d    = s_we_o;
    addr_d  = s_addr_o;
    wdat_d  = s_dat_o;
    rdat_d  = m_dat_o;
    found   = 1'b0;
    pick    = '0;
    sum     = '0;
    // scan from rr_q upward, wrapping modulo N_MASTERS
    for (int i = 0; i < N_MASTERS; i++) begin
      sum = {1'b0, rr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_MASTERS))
        sum = sum - (PW+1)'(N_MASTERS);
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = sum[PW-1:0];
      end
    end
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = pick;
          grant_d = N_MASTERS'(1) << pick;
          cyc_d   = 1'b1;
          we_d    = m_we_i[pick];
          addr_d  = addr_a[pick];
          wdat_d  = wdat_a[pick];
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          rdat_d       = s_dat_i;
          ack_d[own_q] = m_cyc_i[own_q];
          cyc_d        = 1'b0;
          rr_d         = nxt;
          cnt_d        = '0;
          state_d      = RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d[own_q] = 1'b1;
          cyc_d        = 1'b0;
          rr_d         = nxt;
          cnt_d        = '0;
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // controller ack spans several cycles; wait for it to fall
        if (!s_ack_i) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      own_q    <= '0;
      cnt_q    <= '0;
      grant_o  <= '0;
      m_ack_o  <= '0;
      m_err_o  <= '0;
      m_dat_o  <= '0;
      s_cyc_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_addr_o <= '0;
      s_dat_o  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      grant_o  <= grant_d;
      m_ack_o  <= ack_d;
      m_err_o  <= err_d;
      m_dat_o  <= rdat_d;
      s_cyc_o  <= cyc_d;
      s_stb_o  <= cyc_d;
      s_we_o   <= we_d;
      s_addr_o <= addr_d;
      s_dat_o  <= wdat_d;
    end
  end

endmodule
